// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: single-ported, variable-latency memory bus.
//   mem_req   : request active (held until mem_ack)
//   mem_we    : request is a write
//   mem_addr  : word-aligned byte address
//   mem_wdata : write data
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : transaction completes this cycle
// master = sequencer side, slave = memory side.
interface mem_sequencer_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: lets a single-cycle RISC-V core share one single-ported,
// variable-latency memory for instruction fetch and load/store. Each
// instruction is fetched and held, then its data read (load) or
// read-modify-write (store) is performed; PCReady pulses once per retired
// instruction.
// Ports:
//   clk, reset  : clock; synchronous active-high reset
//   PC          : fetch address from core
//   Instr       : registered instruction to core
//   DataAdr     : load/store byte address from core
//   WriteData   : merged store word from core (built from ReadData)
//   MemRead     : current instruction is a load
//   MemWrite    : current instruction is a store
//   ReadData    : registered data word to core
//   PCReady     : one-cycle commit pulse (PC enable, gates RegWrite)
//   InstrCount  : retired-instruction counter (wraps)
//   mem         : memory bus, master side
module mem_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  Instr,
    input  logic [XLEN-1:0]  DataAdr,
    input  logic [XLEN-1:0]  WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [XLEN-1:0]  ReadData,
    output logic             PCReady,
    output logic [31:0]      InstrCount,
    mem_sequencer_if.master  mem
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_DRD,
        S_DWR,
        S_COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [31:0]     count_q, count_d;

    logic            req, we, ready;
    logic [XLEN-1:0] addr, wdata;

    // Memory is word-addressed; the byte offset bits are not needed here.
    logic unused_lsbs;
    assign unused_lsbs = ^{PC[1:0], DataAdr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            instr_q <= NOP_INSTR;
            rdata_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        ready   = 1'b0;

        case (state_q)
            S_FETCH: begin
                req  = 1'b1;
                addr = {PC[XLEN-1:2], 2'b00};
                if (mem.mem_ack) begin
                    instr_d = mem.mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Stores also take the read path so the core can merge
                // sub-word data into the latched word.
                if (MemRead || MemWrite) begin
                    state_d = S_DRD;
                end else begin
                    ready   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DRD: begin
                req  = 1'b1;
                addr = {DataAdr[XLEN-1:2], 2'b00};
                if (mem.mem_ack) begin
                    rdata_d = mem.mem_rdata;
                    state_d = MemWrite ? S_DWR : S_COMMIT;
                end
            end
            S_DWR: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = {DataAdr[XLEN-1:2], 2'b00};
                wdata = WriteData;
                if (mem.mem_ack) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                ready   = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Bus and commit pulse are silenced immediately while in reset, so
        // an in-flight request is dropped without completing.
        if (reset) begin
            req   = 1'b0;
            we    = 1'b0;
            wdata = '0;
            ready = 1'b0;
        end

        count_d = count_q + {31'b0, ready};
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;

    assign Instr      = instr_q;
    assign ReadData   = rdata_q;
    assign PCReady    = ready;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_mem_sequencer.sv
module tb_mem_sequencer;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] PC, Instr, DataAdr, WriteData, ReadData, InstrCount;
    logic        MemRead, MemWrite, PCReady;

    mem_sequencer_if #(.XLEN(XLEN)) mif ();

    mem_sequencer #(.XLEN(XLEN), .NOP_INSTR(32'h0000_0013)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .Instr      (Instr),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ReadData   (ReadData),
        .PCReady    (PCReady),
        .InstrCount (InstrCount),
        .mem        (mif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- tiny core model (addi, lw, sb, sw) ----------------
    logic [31:0] regs [0:31];
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1v, rs2v, imm_i, imm_s, rd_val;
    logic        rf_we;

    always_comb begin
        op        = Instr[6:0];
        f3        = Instr[14:12];
        rs1v      = regs[Instr[19:15]];
        rs2v      = regs[Instr[24:20]];
        imm_i     = {{20{Instr[31]}}, Instr[31:20]};
        imm_s     = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
        MemRead   = (op == 7'h03);
        MemWrite  = (op == 7'h23);
        DataAdr   = rs1v + (MemWrite ? imm_s : imm_i);
        WriteData = ReadData;
        if (MemWrite) begin
            if (f3 == 3'd0) WriteData[8*DataAdr[1:0] +: 8] = rs2v[7:0];
            else            WriteData = rs2v;
        end
        rf_we  = (op == 7'h13) || (op == 7'h03);
        rd_val = (op == 7'h03) ? ReadData : rs1v + imm_i;
    end

    always @(posedge clk) begin
        if (reset) begin
            PC <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (PCReady) begin
            PC <= PC + 32'd4;
            if (rf_we && Instr[11:7] != 5'd0) regs[Instr[11:7]] <= rd_val;
        end
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    logic [31:0] img [0:255];
    int unsigned lat = 0;
    int unsigned wcnt = 0;
    logic        hold_wr = 1'b0;
    logic        spur_en = 1'b0;

    always_comb begin
        mif.mem_rdata = mif.mem_req ? mem[mif.mem_addr[9:2]] : 32'hDEAD_BEEF;
        if (mif.mem_req) mif.mem_ack = (wcnt == lat) && !(hold_wr && mif.mem_we);
        else             mif.mem_ack = spur_en;
    end

    always @(posedge clk) begin
        if (reset) mem <= img;
        else if (mif.mem_req && mif.mem_ack && mif.mem_we)
            mem[mif.mem_addr[9:2]] <= mif.mem_wdata;
        if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct { int cyc; logic [31:0] cnt; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    ret_t exp_ret[$];
    wr_t  exp_wr[$];

    int          cyc = 0;
    int          addr64_cycles = 0;
    int          wr_acks = 0;
    logic        prev_pend = 1'b0, prev_we = 1'b0, prev_idle = 1'b0, prev_rdy = 1'b0;
    logic [31:0] prev_addr, prev_wdata, prev_instr, prev_rd;

    always @(negedge clk) begin
        ret_t er;
        wr_t  ew;
        if (reset) begin
            cyc       = 0;
            prev_pend = 1'b0;
            prev_idle = 1'b0;
            prev_rdy  = 1'b0;
        end else begin
            cyc++;
            if (prev_pend) begin
                check("hs_req_held",   {31'b0, mif.mem_req}, 32'd1);
                check("hs_addr_held",  mif.mem_addr, prev_addr);
                check("hs_we_held",    {31'b0, mif.mem_we}, {31'b0, prev_we});
                check("hs_wdata_held", mif.mem_wdata, prev_wdata);
            end
            if (prev_idle) begin
                check("idle_instr_hold", Instr, prev_instr);
                check("idle_rdata_hold", ReadData, prev_rd);
            end
            if (!mif.mem_we) check("wdata_zero_not_dwr", mif.mem_wdata, 32'd0);
            if (mif.mem_req && mif.mem_addr == 32'h64) addr64_cycles++;
            if (PCReady) begin
                check("pcready_back_to_back", {31'b0, prev_rdy}, 32'd0);
                if (exp_ret.size() == 0) begin
                    check("unexpected_retire_cycle", 32'(cyc), 32'd0);
                end else begin
                    er = exp_ret.pop_front();
                    check("retire_cycle", 32'(cyc), 32'(er.cyc));
                    check("retire_count", InstrCount, er.cnt);
                end
            end
            if (mif.mem_req && mif.mem_ack && mif.mem_we) begin
                wr_acks++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", mif.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    ew = exp_wr.pop_front();
                    check("write_addr", mif.mem_addr, ew.addr);
                    check("write_data", mif.mem_wdata, ew.data);
                end
            end
            prev_pend  = mif.mem_req && !mif.mem_ack;
            prev_we    = mif.mem_we;
            prev_addr  = mif.mem_addr;
            prev_wdata = mif.mem_wdata;
            prev_idle  = !mif.mem_req;
            prev_instr = Instr;
            prev_rd    = ReadData;
            prev_rdy   = PCReady;
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_ret.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(exp_ret.size()), 32'd0);
        check("write_queue_empty", 32'(exp_wr.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;

        // Reset state, with spurious acks on the bus
        clear_img();
        spur_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instr",      Instr, 32'h0000_0013);
        check("rst_readdata",   ReadData, 32'd0);
        check("rst_instrcount", InstrCount, 32'd0);
        check("rst_pcready",    {31'b0, PCReady}, 32'd0);
        check("rst_mem_req",    {31'b0, mif.mem_req}, 32'd0);
        check("rst_mem_we",     {31'b0, mif.mem_we}, 32'd0);
        spur_en = 1'b0;

        // Two addi, zero wait
        clear_img();
        img[0] = 32'h0050_0093;   // addi x1,x0,5
        img[1] = 32'h0030_8113;   // addi x2,x1,3
        lat = 0;
        exp_ret.push_back('{2, 32'd0});
        exp_ret.push_back('{4, 32'd1});
        release_reset();
        @(negedge clk);
        #1;
        check("first_cycle_req",  {31'b0, mif.mem_req}, 32'd1);
        check("first_cycle_addr", mif.mem_addr, 32'd0);
        wait_drain(20);
        check("addi_instrcount", InstrCount, 32'd2);
        check("addi_x1", regs[1], 32'd5);
        check("addi_x2", regs[2], 32'd8);
        enter_reset();

        // lw from 0x64 with 3 wait cycles on every access
        clear_img();
        img[0]  = 32'h0640_2183;  // lw x3,0x64(x0)
        img[25] = 32'h0000_0019;
        lat = 3;
        addr64_cycles = 0;
        exp_ret.push_back('{10, 32'd0});
        release_reset();
        wait_drain(40);
        check("lw_x3",         regs[3], 32'h19);
        check("lw_readdata",   ReadData, 32'h19);
        check("lw_addr_cycles", 32'(addr64_cycles), 32'd4);
        enter_reset();

        // sb 0xAB to 0x65 over 0x11223344, zero wait
        clear_img();
        img[0]  = 32'h0AB0_0293;  // addi x5,x0,0xAB
        img[1]  = 32'h0650_02A3;  // sb x5,0x65(x0)
        img[25] = 32'h1122_3344;
        lat = 0;
        wr_acks = 0;
        exp_ret.push_back('{2, 32'd0});
        exp_ret.push_back('{7, 32'd1});
        exp_wr.push_back('{32'h64, 32'h1122_AB44});
        release_reset();
        wait_drain(30);
        check("sb_write_acks", 32'(wr_acks), 32'd1);
        check("sb_mem_word",   mem[25], 32'h1122_AB44);
        check("sb_readdata",   ReadData, 32'h1122_3344);
        enter_reset();

        // Spurious acks during EXEC/COMMIT on a zero-wait load
        clear_img();
        img[0]  = 32'h0640_2183;
        img[25] = 32'h0000_0019;
        lat = 0;
        spur_en = 1'b1;
        exp_ret.push_back('{4, 32'd0});
        release_reset();
        wait_drain(20);
        check("spur_x3",       regs[3], 32'h19);
        check("spur_readdata", ReadData, 32'h19);
        check("spur_instr",    Instr, 32'h0640_2183);
        enter_reset();
        spur_en = 1'b0;

        // Reset while DWR is waiting for an ack that never comes
        clear_img();
        img[0]  = 32'h0AB0_0293;
        img[1]  = 32'h0650_02A3;
        img[25] = 32'h1122_3344;
        lat = 0;
        hold_wr = 1'b1;
        wr_acks = 0;
        exp_ret.push_back('{2, 32'd0});
        release_reset();
        n = 0;
        while (!mif.mem_we && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("dwr_reached", {31'b0, mif.mem_we}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("dwr_retire_drained", 32'(exp_ret.size()), 32'd0);
        @(negedge clk);
        #1;
        check("dwr_rst_req", {31'b0, mif.mem_req}, 32'd0);
        check("dwr_rst_we",  {31'b0, mif.mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        check("dwr_no_write", 32'(wr_acks), 32'd0);
        hold_wr = 1'b0;
        exp_ret.push_back('{2, 32'd0});
        release_reset();
        @(negedge clk);
        #1;
        check("dwr_restart_req",   {31'b0, mif.mem_req}, 32'd1);
        check("dwr_restart_addr",  mif.mem_addr, 32'd0);
        check("dwr_restart_instr", Instr, 32'h0000_0013);
        check("dwr_restart_rdata", ReadData, 32'd0);
        wait_drain(20);
        enter_reset();

        // InstrCount wrap
        clear_img();
        img[0] = 32'h0050_0093;
        lat = 0;
        exp_ret.push_back('{2, 32'hFFFF_FFFF});
        release_reset();
        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        wait_drain(20);
        check("count_wrap", InstrCount, 32'd0);
        enter_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
